// File: rtl/pwm_capture.sv
// PWM duty-cycle capture: measures the high-time/period ratio of an
// asynchronous PWM input as an 8-bit duty, with stuck and overrun reporting.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] duty_out,
  output logic       duty_valid,
  output logic       stuck,
  output logic       overrun
);

  localparam int NW  = CNT_W + 8;
  localparam int DCW = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [DCW-1:0]   DIV_LEN = DCW'(NW);

  typedef enum logic {ARM, RUN} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             busy_q, busy_d;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [NW-1:0]    num_q, num_d;
  logic [7:0]       duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             ovr_q, ovr_d;

  logic             rise, timeout, close_win, start_div, last_iter;
  logic [NW-1:0]    numer, q_next;
  logic [CNT_W:0]   rem_sh, rem_sub;
  logic [7:0]       q_sat;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop samples the previous stage's old value.
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise    = sync2_q & ~prev_q;
  assign timeout = (per_q == TO_VAL) && !rise && !stuck_q;

  // Control FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARM;
    else     state_q <= state_d;
  end

  // Control FSM: next state
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ARM:     if (rise)    state_d = RUN;
      RUN:     if (timeout) state_d = ARM;
      default:              state_d = ARM;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    close_win = (state_q == RUN) && rise;
  end

  assign start_div = close_win && !busy_q;

  // Window counters; the edge cycle itself is the first cycle of the new window.
  always_comb begin
    per_d  = per_q;
    high_d = high_q;
    if (rise) begin
      per_d  = CNT_W'(1);
      high_d = CNT_W'(1);
    end else begin
      if (per_q != CNT_MAX)             per_d  = per_q + CNT_W'(1);
      if (sync2_q && high_q != CNT_MAX) high_d = high_q + CNT_W'(1);
    end
  end

  assign numer = {high_q, 8'd0} - {8'd0, high_q};

  // Restoring divider; rem_sub's MSB is the borrow, i.e. the inverted quotient bit.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    num_d   = num_q;
    rem_sh  = {rem_q, num_q[NW-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    q_next  = {num_q[NW-2:0], ~rem_sub[CNT_W]};
    if (start_div) begin
      busy_d = 1'b1;
      cnt_d  = DIV_LEN;
      rem_d  = '0;
      dvs_d  = per_q;
      num_d  = numer;
    end else if (busy_q) begin
      num_d = q_next;
      rem_d = rem_sub[CNT_W] ? rem_sh[CNT_W-1:0] : rem_sub[CNT_W-1:0];
      cnt_d = cnt_q - DCW'(1);
      if (cnt_q == DCW'(1)) busy_d = 1'b0;
    end
  end

  assign last_iter = busy_q && (cnt_q == DCW'(1));
  assign q_sat     = (|q_next[NW-1:8]) ? 8'hFF : q_next[7:0];

  // Result and status; a timeout overrides a same-cycle divider completion.
  always_comb begin
    duty_d  = duty_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;
    ovr_d   = close_win && busy_q;
    if (timeout) begin
      duty_d  = sync2_q ? 8'hFF : 8'h00;
      valid_d = 1'b1;
      stuck_d = 1'b1;
    end else begin
      if (last_iter) begin
        duty_d  = q_sat;
        valid_d = 1'b1;
      end
      if (rise) stuck_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q   <= '0;
      high_q  <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      num_q   <= '0;
      duty_q  <= 8'h00;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      per_q   <= per_d;
      high_q  <= high_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      num_q   <= num_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      ovr_q   <= ovr_d;
    end
  end

  assign duty_out   = duty_q;
  assign duty_valid = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: duty ratios, overrun, stuck timeout and
// mid-division reset, with hand-computed expected values.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic       stuck;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcount = 0;
  int ocount = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int rise_cyc = 0;
  logic [7:0] exp_duty = 8'd0;

  pwm_capture #(.CNT_W(16), .TIMEOUT(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor, sampling 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (duty_valid) begin
        vcount++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        check("duty", {24'd0, duty_out}, {24'd0, exp_duty});
      end
      if (overrun) ocount++;
    end
  end

  task automatic square(input int period, input int high, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in   = 1'b1;
      rise_cyc = cyc;
      repeat (high) @(negedge clk);
      pwm_in = 1'b0;
      repeat (period - high) @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int v0, o0;
  int lat;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_duty",    {24'd0, duty_out}, 0);
    check("rst_valid",   {31'd0, duty_valid}, 0);
    check("rst_stuck",   {31'd0, stuck}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 50% square wave, period 100: 127, results 100 cycles apart
    exp_duty = 8'd127;
    v0 = vcount; o0 = ocount;
    square(100, 50, 5);
    repeat (30) @(negedge clk);
    check("sq50_count", vcount - v0, 4);
    check("sq50_spacing", last_valid_cyc - prev_valid_cyc, 100);
    check("sq50_ovr", ocount - o0, 0);

    // Period 51, high 20: 20*255/51 = 100
    reset_dut();
    exp_duty = 8'd100;
    v0 = vcount; o0 = ocount;
    square(51, 20, 6);
    repeat (30) @(negedge clk);
    check("p51_count", vcount - v0, 5);
    check("p51_ovr", ocount - o0, 0);

    // Period 200, high 1: floor(255/200) = 1
    reset_dut();
    exp_duty = 8'd1;
    v0 = vcount;
    square(200, 1, 3);
    repeat (30) @(negedge clk);
    check("p200h1_count", vcount - v0, 2);

    // Period 200, high 199: floor(199*255/200) = 253
    reset_dut();
    exp_duty = 8'd253;
    v0 = vcount;
    square(200, 199, 3);
    repeat (30) @(negedge clk);
    check("p200h199_count", vcount - v0, 2);

    // Period 10, high 5: accept, overrun, overrun repeating over 12 windows
    reset_dut();
    exp_duty = 8'd127;
    v0 = vcount; o0 = ocount;
    square(10, 5, 13);
    repeat (40) @(negedge clk);
    check("p10_valid", vcount - v0, 4);
    check("p10_ovr", ocount - o0, 8);
    check("p10_sum", (vcount - v0) + (ocount - o0), 12);

    // Activity then constant low: one timeout result of 0
    reset_dut();
    exp_duty = 8'd127;
    square(100, 50, 3);
    exp_duty = 8'd0;
    v0 = vcount;
    repeat (1000) @(negedge clk);
    check("to_low_count", vcount - v0, 1);
    check("to_low_duty", {24'd0, duty_out}, 0);
    check("to_low_stuck", {31'd0, stuck}, 1);
    lat = last_valid_cyc - rise_cyc;
    check("to_low_latency", (lat >= 1024 && lat <= 1030) ? 1 : 0, 1);
    repeat (1200) @(negedge clk);
    check("to_once", vcount - v0, 1);
    check("to_stuck_hold", {31'd0, stuck}, 1);

    // Rising edge held high: stuck drops, then a timeout result of 255
    exp_duty = 8'd255;
    v0 = vcount;
    pwm_in   = 1'b1;
    rise_cyc = cyc;
    repeat (6) @(negedge clk);
    check("to_stuck_clear", {31'd0, stuck}, 0);
    repeat (1100) @(negedge clk);
    check("to_high_count", vcount - v0, 1);
    check("to_high_duty", {24'd0, duty_out}, 255);
    check("to_high_stuck", {31'd0, stuck}, 1);
    lat = last_valid_cyc - rise_cyc;
    check("to_high_latency", (lat >= 1024 && lat <= 1030) ? 1 : 0, 1);

    // Reset five cycles into a division
    reset_dut();
    exp_duty = 8'd127;
    square(100, 50, 3);
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    v0 = vcount;
    rst = 1'b1;
    #1;
    check("mid_rst_duty",  {24'd0, duty_out}, 0);
    check("mid_rst_valid", {31'd0, duty_valid}, 0);
    check("mid_rst_stuck", {31'd0, stuck}, 0);
    check("mid_rst_ovr",   {31'd0, overrun}, 0);
    repeat (3) @(negedge clk);
    pwm_in = 1'b0;
    rst    = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_rst_abandon", vcount - v0, 0);
    square(100, 50, 1);
    check("mid_rst_first_edge", vcount - v0, 0);
    square(100, 50, 1);
    check("mid_rst_second_edge", vcount - v0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
